// File: rtl/gate_ctrl_pkg.sv
// Shared types, constants and helpers for the gate envelope controller.
// thr_close is a separate register only when GATE_HYSTERESIS_EN is defined.
package gate_ctrl_pkg;

    localparam int unsigned GAIN_W = 16;
    localparam int unsigned CFG_W  = 16;

    localparam logic [GAIN_W-1:0] GAIN_UNITY = 16'h8000;

    localparam logic [1:0] CFG_ADDR_THR_OPEN  = 2'd0;
    localparam logic [1:0] CFG_ADDR_THR_CLOSE = 2'd1;
    localparam logic [1:0] CFG_ADDR_HOLD      = 2'd2;
    localparam logic [1:0] CFG_ADDR_ENV       = 2'd3;

    typedef enum logic [2:0] {
        CLOSED  = 3'd0,
        ATTACK  = 3'd1,
        OPEN    = 3'd2,
        HOLD    = 3'd3,
        RELEASE = 3'd4
    } gate_state_t;

    // Envelope register layout at CFG_ADDR_ENV
    typedef struct packed {
        logic [3:0]  rel_shift;
        logic [11:0] attack_step;
    } cfg_env_t;

    // |x| with the most negative code clipped to the largest positive one
    function automatic logic [15:0] abs_sat16(input logic signed [15:0] x);
        logic [15:0] neg;
        neg = 16'(~x + 16'd1);
        if (x == 16'sh8000) begin
            return 16'h7fff;
        end
        if (x[15]) begin
            return neg;
        end
        return 16'(x);
    endfunction

endpackage

// File: rtl/gate_gain_mult.sv
// Signed sample times unsigned Q1.15 gain, rounded half-up and saturated.
// Purely combinational.
module gate_gain_mult #(
    parameter int unsigned DATA_W = 16
) (
    input  logic signed [DATA_W-1:0] sample,
    input  logic        [15:0]       gain,
    output logic signed [DATA_W-1:0] scaled_c
);

    localparam int unsigned PW = DATA_W + 18;

    localparam logic signed [PW-1:0] HALF_LSB = PW'(16384);
    localparam logic signed [PW-1:0] SAT_MAX  = PW'((longint'(1) << (DATA_W - 1)) - 1);
    localparam logic signed [PW-1:0] SAT_MIN  = -SAT_MAX - PW'(1);

    logic signed [PW-1:0] prod;
    logic signed [PW-1:0] shifted;

    always_comb begin
        prod    = PW'(sample) * $signed(PW'(gain));
        shifted = (prod + HALF_LSB) >>> 15;
        if (shifted > SAT_MAX) begin
            scaled_c = DATA_W'(SAT_MAX);
        end else if (shifted < SAT_MIN) begin
            scaled_c = DATA_W'(SAT_MIN);
        end else begin
            scaled_c = DATA_W'(shifted);
        end
    end

endmodule

// File: rtl/gate_envelope_ctrl.sv
// Noise-gate controller: envelope FSM driving a Q1.15 gain on a valid/ready stream.
// Define GATE_HYSTERESIS_EN for an independent close threshold.
module gate_envelope_ctrl
    import gate_ctrl_pkg::*;
#(
    parameter int unsigned DATA_W        = 16,
    parameter int unsigned THR_OPEN_DEF  = 1000,
    parameter int unsigned THR_CLOSE_DEF = 800,
    parameter int unsigned HOLD_DEF      = 3000,
    parameter int unsigned ATTACK_DEF    = 2048,
    parameter int unsigned REL_SHIFT_DEF = 1
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     s_valid,
    output logic                     s_ready,
    input  logic signed [DATA_W-1:0] s_sample,
    output logic                     m_valid,
    input  logic                     m_ready,
    output logic signed [DATA_W-1:0] m_sample,
    input  logic                     bypass,
    input  logic                     cfg_we,
    input  logic        [1:0]        cfg_addr,
    input  logic        [CFG_W-1:0]  cfg_wdata,
    output logic        [GAIN_W-1:0] gain,
    output logic        [2:0]        gate_state
);

    localparam logic [15:0] THR_OPEN_RST = 16'(THR_OPEN_DEF);
    localparam logic [15:0] HOLD_RST     = 16'(HOLD_DEF);
    localparam cfg_env_t    ENV_RST      = cfg_env_t'{rel_shift:   4'(REL_SHIFT_DEF),
                                                      attack_step: 12'(ATTACK_DEF)};

    logic [15:0] thr_open_q, thr_open_d;
    logic [15:0] hold_q, hold_d;
    cfg_env_t    env_q, env_d;
`ifdef GATE_HYSTERESIS_EN
    localparam logic [15:0] THR_CLOSE_RST = 16'(THR_CLOSE_DEF);
    logic [15:0] thr_close_q, thr_close_d;
`endif

    gate_state_t        state_q, state_d;
    logic [GAIN_W-1:0]  gain_q, gain_d;
    logic [15:0]        hold_cnt_q, hold_cnt_d;
    logic               m_valid_q, m_valid_d;
    logic signed [DATA_W-1:0] m_sample_q, m_sample_d;
    logic signed [DATA_W-1:0] scaled;

    logic        accept;
    logic [15:0] mag;
    logic [15:0] thr_close_eff;
    logic [15:0] attack_step_eff;
    logic [3:0]  rel_shift_eff;
    logic [16:0] gain_sum;
    logic [15:0] gain_att;
    logic [15:0] gain_shr;
    logic [15:0] rel_dec;
    logic [15:0] gain_rel;
    logic        open_hit;
    logic        hold_done;

    assign s_ready    = !m_valid_q || m_ready;
    assign accept     = s_valid && s_ready;
    assign m_valid    = m_valid_q;
    assign m_sample   = m_sample_q;
    assign gain       = gain_q;
    assign gate_state = state_q;

    gate_gain_mult #(
        .DATA_W (DATA_W)
    ) u_gain_mult (
        .sample   (s_sample),
        .gain     (gain_q),
        .scaled_c (scaled)
    );

    // Config writes are forwarded so a write coinciding with an accept already applies
    always_comb begin
        thr_open_d = thr_open_q;
        hold_d     = hold_q;
        env_d      = env_q;
`ifdef GATE_HYSTERESIS_EN
        thr_close_d = thr_close_q;
`endif
        if (cfg_we) begin
            case (cfg_addr)
                CFG_ADDR_THR_OPEN: thr_open_d = cfg_wdata;
`ifdef GATE_HYSTERESIS_EN
                CFG_ADDR_THR_CLOSE: thr_close_d = cfg_wdata;
`endif
                CFG_ADDR_HOLD:     hold_d = cfg_wdata;
                CFG_ADDR_ENV:      env_d  = cfg_env_t'(cfg_wdata);
                default: ;
            endcase
        end
    end

`ifdef GATE_HYSTERESIS_EN
    assign thr_close_eff = thr_close_d;
`else
    assign thr_close_eff = thr_open_d;
`endif

    // Gain arithmetic shared by the FSM
    always_comb begin
        mag             = abs_sat16(16'(s_sample));
        attack_step_eff = (env_d.attack_step == 12'd0) ? 16'd1 : 16'(env_d.attack_step);
        rel_shift_eff   = (env_d.rel_shift == 4'd0) ? 4'd1 : env_d.rel_shift;
        gain_sum        = 17'(gain_q) + 17'(attack_step_eff);
        gain_att        = (gain_sum >= 17'(GAIN_UNITY)) ? GAIN_UNITY : gain_sum[15:0];
        gain_shr        = gain_q >> rel_shift_eff;
        rel_dec         = (gain_shr == 16'd0) ? 16'd1 : gain_shr;
        gain_rel        = (gain_q > rel_dec) ? (gain_q - rel_dec) : 16'd0;
        open_hit        = mag > thr_open_d;
        hold_done       = (hold_d == 16'd0) || (hold_cnt_q >= (hold_d - 16'd1));
    end

    // Envelope FSM, advancing once per accepted sample
    always_comb begin
        state_d    = state_q;
        gain_d     = gain_q;
        hold_cnt_d = hold_cnt_q;
        if (accept) begin
            case (state_q)
                CLOSED: begin
                    gain_d = '0;
                    if (open_hit) begin
                        gain_d  = gain_att;
                        state_d = (gain_att == GAIN_UNITY) ? OPEN : ATTACK;
                    end
                end
                ATTACK: begin
                    gain_d  = gain_att;
                    state_d = (gain_att == GAIN_UNITY) ? OPEN : ATTACK;
                end
                OPEN: begin
                    gain_d = GAIN_UNITY;
                    if (mag <= thr_close_eff) begin
                        hold_cnt_d = '0;
                        state_d    = (hold_d == 16'd0) ? RELEASE : HOLD;
                    end
                end
                HOLD: begin
                    if (open_hit) begin
                        state_d = OPEN;
                    end else begin
                        hold_cnt_d = hold_cnt_q + 16'd1;
                        if (hold_done) begin
                            state_d = RELEASE;
                        end
                    end
                end
                RELEASE: begin
                    if (open_hit) begin
                        gain_d  = gain_att;
                        state_d = (gain_att == GAIN_UNITY) ? OPEN : ATTACK;
                    end else begin
                        gain_d = gain_rel;
                        if (gain_rel == 16'd0) begin
                            state_d = CLOSED;
                        end
                    end
                end
                default: begin
                    state_d = CLOSED;
                    gain_d  = '0;
                end
            endcase
        end
    end

    // Output register: load on accept, drop valid once drained
    always_comb begin
        m_valid_d  = m_valid_q;
        m_sample_d = m_sample_q;
        if (accept) begin
            m_valid_d  = 1'b1;
            m_sample_d = bypass ? s_sample : scaled;
        end else if (m_ready) begin
            m_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            thr_open_q <= THR_OPEN_RST;
            hold_q     <= HOLD_RST;
            env_q      <= ENV_RST;
`ifdef GATE_HYSTERESIS_EN
            thr_close_q <= THR_CLOSE_RST;
`endif
            state_q    <= CLOSED;
            gain_q     <= '0;
            hold_cnt_q <= '0;
            m_valid_q  <= 1'b0;
            m_sample_q <= '0;
        end else begin
            thr_open_q <= thr_open_d;
            hold_q     <= hold_d;
            env_q      <= env_d;
`ifdef GATE_HYSTERESIS_EN
            thr_close_q <= thr_close_d;
`endif
            state_q    <= state_d;
            gain_q     <= gain_d;
            hold_cnt_q <= hold_cnt_d;
            m_valid_q  <= m_valid_d;
            m_sample_q <= m_sample_d;
        end
    end

endmodule

// File: tb/tb_gate_envelope_ctrl.sv
// Self-checking bench for gate_envelope_ctrl: vector table, directed corner sequences,
// then random traffic against an integer reference model.
module tb_gate_envelope_ctrl;

    localparam int ST_CLOSED  = 0;
    localparam int ST_ATTACK  = 1;
    localparam int ST_OPEN    = 2;
    localparam int ST_HOLD    = 3;
    localparam int ST_RELEASE = 4;
`ifdef GATE_HYSTERESIS_EN
    localparam bit HYST = 1'b1;
`else
    localparam bit HYST = 1'b0;
`endif

    logic               clk = 1'b0;
    logic               rst_n = 1'b0;
    logic               s_valid = 1'b0;
    logic               s_ready;
    logic signed [15:0] s_sample = '0;
    logic               m_valid;
    logic               m_ready = 1'b0;
    logic signed [15:0] m_sample;
    logic               bypass = 1'b0;
    logic               cfg_we = 1'b0;
    logic [1:0]         cfg_addr = '0;
    logic [15:0]        cfg_wdata = '0;
    logic [15:0]        gain;
    logic [2:0]         gate_state;

    gate_envelope_ctrl dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .s_valid    (s_valid),
        .s_ready    (s_ready),
        .s_sample   (s_sample),
        .m_valid    (m_valid),
        .m_ready    (m_ready),
        .m_sample   (m_sample),
        .bypass     (bypass),
        .cfg_we     (cfg_we),
        .cfg_addr   (cfg_addr),
        .cfg_wdata  (cfg_wdata),
        .gain       (gain),
        .gate_state (gate_state)
    );

    always #5 clk = ~clk;

    int n_cmp  = 0;
    int n_fail = 0;

    // Reference model state (plain integers)
    int m_state, m_gain, m_cnt;
    int m_thr_open, m_thr_close, m_hold, m_att, m_sh;
    bit mdl_mv;
    int mdl_ms;

    typedef struct {
        int x;
        int exp_out;
        int exp_gain;
        int exp_state;
    } vec_t;

    vec_t vecs[27];

    task automatic chk(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic int sat16(input longint v);
        if (v > 32767) return 32767;
        if (v < -32768) return -32768;
        return int'(v);
    endfunction

    function automatic vec_t mk(input int x, input int o, input int g, input int s);
        vec_t v;
        v.x = x; v.exp_out = o; v.exp_gain = g; v.exp_state = s;
        return v;
    endfunction

    task automatic mdl_reset();
        m_state = ST_CLOSED; m_gain = 0; m_cnt = 0;
        m_thr_open = 1000; m_thr_close = 800; m_hold = 3000; m_att = 2048; m_sh = 1;
        mdl_mv = 1'b0; mdl_ms = 0;
    endtask

    task automatic mdl_cfg(input int addr, input int data);
        case (addr)
            0: m_thr_open = data;
            1: if (HYST) m_thr_close = data;
            2: m_hold = data;
            default: begin
                m_att = data % 4096;
                m_sh  = data / 4096;
            end
        endcase
    endtask

    task automatic mdl_attack(input int stp);
        m_gain = m_gain + stp;
        if (m_gain >= 32768) begin
            m_gain  = 32768;
            m_state = ST_OPEN;
        end else begin
            m_state = ST_ATTACK;
        end
    endtask

    task automatic mdl_sample(input int x, input bit byp);
        int mag, stp, sh, thr_c, d;
        longint p;
        mag = (x < 0) ? -x : x;
        if (mag > 32767) mag = 32767;
        p = longint'(x) * longint'(m_gain) + 64'sd16384;
        mdl_ms = byp ? x : sat16(p >>> 15);
        stp   = (m_att == 0) ? 1 : m_att;
        sh    = (m_sh == 0) ? 1 : m_sh;
        thr_c = HYST ? m_thr_close : m_thr_open;
        case (m_state)
            ST_CLOSED:  if (mag > m_thr_open) mdl_attack(stp);
            ST_ATTACK:  mdl_attack(stp);
            ST_OPEN: begin
                if (mag <= thr_c) begin
                    m_cnt   = 0;
                    m_state = (m_hold == 0) ? ST_RELEASE : ST_HOLD;
                end
            end
            ST_HOLD: begin
                if (mag > m_thr_open) begin
                    m_state = ST_OPEN;
                end else begin
                    m_cnt++;
                    if (m_hold == 0 || m_cnt >= m_hold) m_state = ST_RELEASE;
                end
            end
            default: begin
                if (mag > m_thr_open) begin
                    mdl_attack(stp);
                end else begin
                    d = m_gain >> sh;
                    if (d < 1) d = 1;
                    m_gain = m_gain - d;
                    if (m_gain <= 0) begin
                        m_gain  = 0;
                        m_state = ST_CLOSED;
                    end
                end
            end
        endcase
    endtask

    // One clock: drive on falling edge, check after rising edge against the model
    task automatic step(input bit v, input int x, input bit byp, input bit mr,
                        input bit we, input int addr, input int data);
        bit exp_rdy;
        @(negedge clk);
        s_valid = v; s_sample = 16'(x); bypass = byp; m_ready = mr;
        cfg_we = we; cfg_addr = 2'(addr); cfg_wdata = 16'(data);
        #1;
        exp_rdy = !mdl_mv || mr;
        chk("s_ready", int'(s_ready), int'(exp_rdy));
        @(posedge clk);
        if (we) mdl_cfg(addr, data);
        if (v && exp_rdy) begin
            mdl_sample(x, byp);
            mdl_mv = 1'b1;
        end else if (mr) begin
            mdl_mv = 1'b0;
        end
        #1;
        chk("m_valid", int'(m_valid), int'(mdl_mv));
        chk("m_sample", int'(m_sample), mdl_ms);
        chk("gain", int'(gain), m_gain);
        chk("gate_state", int'(gate_state), m_state);
    endtask

    task automatic send(input int x);
        step(1'b1, x, 1'b0, 1'b1, 1'b0, 0, 0);
    endtask

    task automatic cfg_write(input int addr, input int data);
        step(1'b0, 0, 1'b0, 1'b1, 1'b1, addr, data);
    endtask

    task automatic expect_lit(input string name, input int out, input int g, input int st);
        chk({name, "_out"}, int'(m_sample), out);
        chk({name, "_gain"}, int'(gain), g);
        chk({name, "_state"}, int'(gate_state), st);
    endtask

    initial begin
        int x, r;
        for (int i = 0; i < 10; i++) vecs[i] = mk(500, 0, 0, ST_CLOSED);
        for (int k = 0; k < 16; k++)
            vecs[10 + k] = mk(4000, 250 * k, 2048 * (k + 1), (k == 15) ? ST_OPEN : ST_ATTACK);
        vecs[26] = mk(4000, 4000, 32768, ST_OPEN);

        mdl_reset();
        repeat (2) @(negedge clk);
        chk("rst_m_valid", int'(m_valid), 0);
        chk("rst_m_sample", int'(m_sample), 0);
        chk("rst_gain", int'(gain), 0);
        chk("rst_state", int'(gate_state), ST_CLOSED);
        rst_n = 1'b1;

        // Quiet samples stay gated, then a loud burst ramps to unity
        for (int i = 0; i < 27; i++) begin
            send(vecs[i].x);
            expect_lit($sformatf("vec%0d", i), vecs[i].exp_out, vecs[i].exp_gain, vecs[i].exp_state);
        end

        // Bypass and saturation at unity gain
        step(1'b1, -32768, 1'b1, 1'b1, 1'b0, 0, 0);
        expect_lit("bypass_min", -32768, 32768, ST_OPEN);
        send(-32768);
        expect_lit("unity_min", -32768, 32768, ST_OPEN);

        // Backpressure: output held, FSM frozen
        for (int i = 0; i < 5; i++) begin
            step(1'b1, 1234, 1'b0, 1'b0, 1'b0, 0, 0);
            chk("bp_s_ready", int'(s_ready), 0);
            expect_lit("bp", -32768, 32768, ST_OPEN);
        end
        send(1234);
        expect_lit("bp_release", 1234, 32768, ST_OPEN);

        // Close threshold: 900 sits between 800 and 1000
        cfg_write(1, 800);
        send(900);
        expect_lit("hyst", 900, 32768, HYST ? ST_OPEN : ST_HOLD);
        send(5000);
        expect_lit("reopen", 5000, 32768, ST_OPEN);

        // Hold of 4 samples, then release; re-attack from partial gain
        cfg_write(2, 4);
        for (int i = 0; i < 4; i++) begin
            send(0);
            expect_lit("hold", 0, 32768, ST_HOLD);
        end
        send(0);
        expect_lit("rel_entry", 0, 32768, ST_RELEASE);
        for (int k = 1; k <= 3; k++) begin
            send(0);
            expect_lit("rel_a", 0, 32768 >> k, ST_RELEASE);
        end
        send(-5000);
        expect_lit("reattack", -625, 6144, ST_ATTACK);
        for (int i = 0; i < 20; i++) send(-5000);
        expect_lit("reopened", -5000, 32768, ST_OPEN);

        // Full release down to zero
        for (int i = 0; i < 5; i++) send(0);
        chk("rel_full_entry", int'(gate_state), ST_RELEASE);
        for (int k = 1; k <= 16; k++) begin
            send(0);
            expect_lit("rel_full", 0, (k < 16) ? (32768 >> k) : 0, (k < 16) ? ST_RELEASE : ST_CLOSED);
        end

        // attack_step 0 acts as 1; a write coinciding with an accept applies to it
        cfg_write(3, 'h1000);
        send(5000);
        expect_lit("step0", 0, 1, ST_ATTACK);
        step(1'b1, 5000, 1'b0, 1'b1, 1'b1, 3, 'h1800);
        expect_lit("fwd_cfg", 0, 2049, ST_ATTACK);

        // Async reset with a stalled output pending
        step(1'b1, 777, 1'b0, 1'b0, 1'b0, 0, 0);
        chk("pend_valid", int'(m_valid), 1);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("midrst_valid", int'(m_valid), 0);
        chk("midrst_sample", int'(m_sample), 0);
        chk("midrst_gain", int'(gain), 0);
        chk("midrst_state", int'(gate_state), ST_CLOSED);
        mdl_reset();
        @(negedge clk);
        rst_n = 1'b1;
        send(900);
        expect_lit("post_rst_quiet", 0, 0, ST_CLOSED);
        send(1001);
        expect_lit("post_rst_open", 0, 2048, ST_ATTACK);

        // Random traffic against the model
        for (int i = 0; i < 3000; i++) begin
            r = int'($urandom_range(0, 9));
            if (r < 4)      x = int'($urandom_range(0, 1500));
            else if (r < 8) x = int'($urandom_range(0, 32767));
            else if (r == 8) x = -32768;
            else            x = 0;
            if ($urandom_range(0, 1) == 1 && x > 0) x = -x;
            if ($urandom_range(0, 19) == 0) begin
                r = int'($urandom_range(0, 3));
                case (r)
                    0, 1:    step(1'b1, x, 1'b0, 1'b1, 1'b1, r, int'($urandom_range(0, 6000)));
                    2:       step(1'b1, x, 1'b0, 1'b1, 1'b1, 2, int'($urandom_range(0, 12)));
                    default: step(1'b1, x, 1'b0, 1'b1, 1'b1, 3,
                                  int'($urandom_range(0, 4)) * 4096 + int'($urandom_range(0, 4095)));
                endcase
            end else begin
                step($urandom_range(0, 3) != 0, x, $urandom_range(0, 7) == 0,
                     $urandom_range(0, 3) != 0, 1'b0, 0, 0);
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
